// File: rtl/agc_seq_pkg.sv
// rtl/agc_seq_pkg.sv - op codes, FSM encoding and step-entry layout for the AGC sequencer
package agc_seq_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_SET   = 2'd0;
    localparam logic [OP_W-1:0] OP_CLR   = 2'd1;
    localparam logic [OP_W-1:0] OP_PULSE = 2'd2;
    localparam logic [OP_W-1:0] OP_END   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PULSE,
        ST_DONE
    } seq_state_e;

    // Entry layout, MSB first: {op, mask, delay, plen}
    function automatic int entry_width(input int nch, input int tw, input int pw);
        return OP_W + nch + tw + pw;
    endfunction

endpackage

// File: rtl/agc_clock_div.sv
// rtl/agc_clock_div.sv - free-running toggle divider producing the AGC CLOCK from SIM_CLK
module agc_clock_div #(
    parameter int CLK_HALF = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic clk_o
);
    localparam int CNT_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (cnt_q == CNT_W'(CLK_HALF - 1)) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/agc_monitor_sequencer.sv
// rtl/agc_monitor_sequencer.sv - table-driven set/clear/pulse sequencer for AGC monitor discretes
module agc_monitor_sequencer
    import agc_seq_pkg::*;
#(
    parameter int             NCH      = 8,
    parameter int             DEPTH    = 16,
    parameter int             TW       = 24,
    parameter int             PW       = 16,
    parameter logic [NCH-1:0] INIT_VAL = '0,
    parameter int             CLK_HALF = 12
) (
    input  logic                     SIM_CLK,
    input  logic                     SIM_RST,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [OP_W-1:0]          wr_op,
    input  logic [NCH-1:0]           wr_mask,
    input  logic [TW-1:0]            wr_delay,
    input  logic [PW-1:0]            wr_plen,
    input  logic                     start,
    input  logic                     abort,
    output logic [NCH-1:0]           chan,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     CLOCK
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = (TW > PW) ? TW : PW;
    localparam int            EW       = entry_width(NCH, TW, PW);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [EW-1:0]   table_q [DEPTH];
    logic [EW-1:0]   entry;
    logic [OP_W-1:0] f_op;
    logic [NCH-1:0]  f_mask;
    logic [TW-1:0]   f_delay;
    logic [PW-1:0]   f_plen;

    seq_state_e      state_q;
    logic [NCH-1:0]  chan_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_err_q;
    logic [AW-1:0]   step_idx_q;
    logic [CW-1:0]   cnt_q;
    logic [OP_W-1:0] op_q;
    logic [NCH-1:0]  mask_q;
    logic [PW-1:0]   plen_q;

    // Table is plain storage with no reset; it only accepts writes while idle.
    always_ff @(posedge SIM_CLK) begin
        if (wr_en && state_q == ST_IDLE) begin
            table_q[wr_addr] <= {wr_op, wr_mask, wr_delay, wr_plen};
        end
    end

    assign entry   = table_q[step_idx_q];
    assign f_op    = entry[EW-1 -: OP_W];
    assign f_mask  = entry[TW+PW +: NCH];
    assign f_delay = entry[PW +: TW];
    assign f_plen  = entry[0 +: PW];

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q    <= ST_IDLE;
            chan_q     <= INIT_VAL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            step_idx_q <= '0;
            cnt_q      <= '0;
            op_q       <= OP_END;
            mask_q     <= '0;
            plen_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= wr_en && (state_q != ST_IDLE);
            if (abort) begin
                state_q <= ST_IDLE;
                chan_q  <= INIT_VAL;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q    <= ST_FETCH;
                            busy_q     <= 1'b1;
                            step_idx_q <= '0;
                        end
                    end
                    ST_FETCH: begin
                        op_q   <= f_op;
                        mask_q <= f_mask;
                        plen_q <= f_plen;
                        cnt_q  <= CW'(f_delay);
                        if (f_op == OP_END) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (op_q == OP_SET || op_q == OP_CLR) begin
                            chan_q <= (op_q == OP_SET) ? (chan_q | mask_q) : (chan_q & ~mask_q);
                            if (step_idx_q == LAST_IDX) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= ST_FETCH;
                                step_idx_q <= step_idx_q + 1'b1;
                            end
                        end else begin
                            // Counter holds remaining high cycles minus one; plen=0 still gives one cycle.
                            chan_q  <= chan_q | mask_q;
                            cnt_q   <= (plen_q == '0) ? '0 : CW'(plen_q) - CW'(1);
                            state_q <= ST_PULSE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            chan_q <= chan_q & ~mask_q;
                            if (step_idx_q == LAST_IDX) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= ST_FETCH;
                                step_idx_q <= step_idx_q + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    agc_clock_div #(
        .CLK_HALF(CLK_HALF)
    ) u_clk_div (
        .clk_i(SIM_CLK),
        .rst_i(SIM_RST),
        .clk_o(CLOCK)
    );

    assign chan     = chan_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_err   = wr_err_q;
    assign step_idx = step_idx_q;

endmodule

// File: tb/tb_agc_monitor_sequencer.sv
// tb/tb_agc_monitor_sequencer.sv - self-checking bench for agc_monitor_sequencer
module tb_agc_monitor_sequencer;
    import agc_seq_pkg::*;

    localparam int NCH      = 8;
    localparam int DEPTH    = 16;
    localparam int TW       = 24;
    localparam int PW       = 16;
    localparam int CLK_HALF = 12;
    localparam int MAXR     = 4096;

    logic            SIM_CLK = 1'b0;
    logic            SIM_RST;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [1:0]      wr_op;
    logic [NCH-1:0]  wr_mask;
    logic [TW-1:0]   wr_delay;
    logic [PW-1:0]   wr_plen;
    logic            start;
    logic            abort;
    logic [NCH-1:0]  chan;
    logic            busy;
    logic            done;
    logic            wr_err;
    logic [3:0]      step_idx;
    logic            CLOCK;

    agc_monitor_sequencer #(
        .NCH(NCH), .DEPTH(DEPTH), .TW(TW), .PW(PW),
        .INIT_VAL(8'h00), .CLK_HALF(CLK_HALF)
    ) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_mask(wr_mask),
        .wr_delay(wr_delay), .wr_plen(wr_plen),
        .start(start), .abort(abort),
        .chan(chan), .busy(busy), .done(done), .wr_err(wr_err),
        .step_idx(step_idx), .CLOCK(CLOCK)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct {
        logic [1:0] op;
        logic [7:0] mask;
        int         delay;
        int         plen;
    } step_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] mask;
        int         delay;
        int         plen;
        logic [7:0] pre;
        logic [7:0] mid;
        logic [7:0] fin;
        int         done_rel;
    } vec_t;

    int nvec = 0;
    int nbad = 0;

    step_t      prog [DEPTH];
    logic [7:0] mdl_chan = 8'h00;
    int         e_done_at;
    logic [7:0] e_chan [MAXR];
    bit         e_busy [MAXR];
    bit         e_done [MAXR];
    logic [3:0] e_idx  [MAXR];
    logic [7:0] a_chan [MAXR];
    bit         a_busy [MAXR];
    bit         a_done [MAXR];
    bit         a_err  [MAXR];
    logic [3:0] a_idx  [MAXR];

    int since = 0;
    bit clk_armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CLOCK must equal the parity of whole half-periods elapsed since the last reset edge.
    always @(posedge SIM_CLK) begin
        if (SIM_RST) since <= 0;
        else         since <= since + 1;
    end

    always @(negedge SIM_CLK) begin
        if (clk_armed) check("CLOCK phase", 32'(CLOCK), 32'((since / CLK_HALF) % 2));
    end

    function automatic void fill(input int a, input int b, input logic [7:0] ch,
                                 input bit bz, input bit dn, input int idx);
        for (int r = a; r <= b; r++) begin
            if (r >= 0 && r < MAXR) begin
                e_chan[r] = ch;
                e_busy[r] = bz;
                e_done[r] = dn;
                e_idx[r]  = 4'(idx);
            end
        end
    endfunction

    // Timeline model: entry fetched at t acts at t+delay+2; a pulse lasts max(plen,1) cycles.
    function automatic void build_model();
        logic [7:0] ch;
        int t, act, nxt, p;
        ch = mdl_chan;
        t = 0;
        e_done_at = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (prog[i].op == OP_END) begin
                fill(t, t, ch, 1'b1, 1'b0, i);
                e_done_at = t + 1;
                fill(t + 1, t + 1, ch, 1'b0, 1'b1, i);
                fill(t + 2, t + 5, ch, 1'b0, 1'b0, i);
                break;
            end
            act = t + prog[i].delay + 2;
            fill(t, act - 1, ch, 1'b1, 1'b0, i);
            if (prog[i].op == OP_PULSE) begin
                p = (prog[i].plen == 0) ? 1 : prog[i].plen;
                fill(act, act + p - 1, ch | prog[i].mask, 1'b1, 1'b0, i);
                ch = ch & ~prog[i].mask;
                nxt = act + p;
            end else begin
                ch = (prog[i].op == OP_SET) ? (ch | prog[i].mask) : (ch & ~prog[i].mask);
                nxt = act;
            end
            if (i == DEPTH - 1) begin
                e_done_at = nxt;
                fill(nxt, nxt, ch, 1'b0, 1'b1, i);
                fill(nxt + 1, nxt + 5, ch, 1'b0, 1'b0, i);
            end
            t = nxt;
        end
        mdl_chan = ch;
    endfunction

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en    = 1'b1;
            wr_addr  = 4'(i);
            wr_op    = prog[i].op;
            wr_mask  = prog[i].mask;
            wr_delay = TW'(prog[i].delay);
            wr_plen  = PW'(prog[i].plen);
            @(negedge SIM_CLK);
        end
        wr_en = 1'b0;
    endtask

    task automatic clear_chan();
        abort = 1'b1;
        @(negedge SIM_CLK);
        abort = 1'b0;
        check("abort in idle restores INIT_VAL", 32'(chan), 32'h0);
        mdl_chan = 8'h00;
    endtask

    task automatic run_prog(input int wr_at, input int st_at, input int ab_at);
        int  last;
        bit  e_err;
        build_model();
        start = 1'b1;
        @(negedge SIM_CLK);
        start = 1'b0;
        last = (ab_at >= 0) ? ab_at : e_done_at + 4;
        for (int rel = 0; rel <= last; rel++) begin
            a_chan[rel] = chan;
            a_busy[rel] = busy;
            a_done[rel] = done;
            a_err[rel]  = wr_err;
            a_idx[rel]  = step_idx;
            e_err = (wr_at >= 0) && (rel == wr_at + 1);
            check($sformatf("rel %0d {chan,busy,done,wr_err,step_idx}", rel),
                  32'({chan, busy, done, wr_err, step_idx}),
                  32'({e_chan[rel], e_busy[rel], e_done[rel], e_err, e_idx[rel]}));
            wr_en = (rel == wr_at);
            if (rel == wr_at) begin
                wr_addr  = 4'd0;
                wr_op    = OP_SET;
                wr_mask  = 8'hF0;
                wr_delay = '0;
                wr_plen  = '0;
            end
            start = (rel == st_at);
            abort = (rel == ab_at);
            @(negedge SIM_CLK);
        end
        wr_en = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        if (ab_at >= 0) begin
            mdl_chan = 8'h00;
            for (int k = 0; k < 5; k++) begin
                check($sformatf("after abort +%0d {chan,busy,done}", k),
                      32'({chan, busy, done}), 32'h0);
                @(negedge SIM_CLK);
            end
        end
    endtask

    vec_t vt [7];

    initial begin
        int endpos;
        vt[0] = '{OP_SET,   8'h0F, 3,  0, 8'h30, 8'h3F, 8'h3F, 8};
        vt[1] = '{OP_CLR,   8'h21, 0,  0, 8'h33, 8'h12, 8'h12, 5};
        vt[2] = '{OP_PULSE, 8'h03, 2,  4, 8'h81, 8'h83, 8'h80, 11};
        vt[3] = '{OP_PULSE, 8'h40, 0,  0, 8'h00, 8'h40, 8'h00, 6};
        vt[4] = '{OP_SET,   8'h80, 10, 0, 8'hFF, 8'hFF, 8'hFF, 15};
        vt[5] = '{OP_CLR,   8'hFF, 1,  0, 8'hA5, 8'h00, 8'h00, 6};
        vt[6] = '{OP_PULSE, 8'h01, 1,  1, 8'h01, 8'h01, 8'h00, 7};

        SIM_RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_op = '0; wr_mask = '0;
        wr_delay = '0; wr_plen = '0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog[i] = '{OP_END, 8'h00, 0, 0};
        repeat (3) @(negedge SIM_CLK);
        check("reset {chan,busy,done,wr_err,step_idx,CLOCK}",
              32'({chan, busy, done, wr_err, step_idx, CLOCK}), 32'h0);
        clk_armed = 1'b1;
        SIM_RST = 1'b0;
        @(negedge SIM_CLK);

        // Single-action vectors, each preceded by a SET that establishes the prior level.
        for (int v = 0; v < 7; v++) begin
            clear_chan();
            for (int i = 0; i < DEPTH; i++) prog[i] = '{OP_END, 8'h00, 0, 0};
            prog[0] = '{OP_SET, vt[v].pre, 0, 0};
            prog[1] = '{vt[v].op, vt[v].mask, vt[v].delay, vt[v].plen};
            load_prog();
            run_prog(-1, -1, -1);
            check($sformatf("vec %0d chan before action", v), 32'(a_chan[vt[v].delay + 3]), 32'(vt[v].pre));
            check($sformatf("vec %0d chan at action", v), 32'(a_chan[vt[v].delay + 4]), 32'(vt[v].mid));
            check($sformatf("vec %0d done timing", v),
                  32'({a_done[vt[v].done_rel - 1], a_done[vt[v].done_rel]}), 32'b01);
            check($sformatf("vec %0d final chan", v), 32'(a_chan[vt[v].done_rel]), 32'(vt[v].fin));
        end

        // Long pulse: rise 2602 cycles after the first fetch, 250 cycles wide.
        clear_chan();
        for (int i = 0; i < DEPTH; i++) prog[i] = '{OP_END, 8'h00, 0, 0};
        prog[0] = '{OP_PULSE, 8'h01, 2600, 250};
        load_prog();
        run_prog(-1, -1, -1);
        check("long pulse edges", 32'({a_chan[2601][0], a_chan[2602][0], a_chan[2851][0], a_chan[2852][0]}), 32'b0110);
        check("long pulse done/busy", 32'({a_done[2853], a_busy[2853], a_busy[2852]}), 32'b101);

        // SET then delayed CLR, step index walk.
        clear_chan();
        prog[0] = '{OP_SET, 8'h05, 0, 0};
        prog[1] = '{OP_CLR, 8'h04, 3, 0};
        prog[2] = '{OP_END, 8'h00, 0, 0};
        load_prog();
        run_prog(-1, -1, -1);
        check("set/clr chan trace", 32'({a_chan[1], a_chan[2], a_chan[6], a_chan[7]}), 32'h00050501);
        check("set/clr step_idx", 32'({a_idx[0], a_idx[2], a_idx[7]}), 32'h012);
        check("set/clr done", 32'(a_done[8]), 32'h1);

        // Full table without END: finishes after entry 15 with no wrap.
        clear_chan();
        for (int i = 0; i < DEPTH; i++) prog[i] = '{OP_SET, 8'(1 << (i % 8)), 0, 0};
        load_prog();
        run_prog(-1, -1, -1);
        check("full table done at 32", 32'({a_busy[31], a_done[32], a_busy[32]}), 32'b110);
        check("full table idx no wrap", 32'({a_idx[32], a_idx[35]}), 32'hFF);
        check("full table chan", 32'(a_chan[32]), 32'hFF);

        // Abort mid-pulse, then rerun from entry 0.
        clear_chan();
        for (int i = 0; i < DEPTH; i++) prog[i] = '{OP_END, 8'h00, 0, 0};
        prog[0] = '{OP_PULSE, 8'h01, 5, 100};
        load_prog();
        run_prog(-1, -1, 47);
        run_prog(-1, -1, -1);

        // Write and start while busy are both rejected; rerun proves entry 0 unchanged.
        clear_chan();
        prog[0] = '{OP_SET, 8'h02, 20, 0};
        load_prog();
        run_prog(5, 9, -1);
        check("wr_err one cycle", 32'({a_err[5], a_err[6], a_err[7]}), 32'b010);
        run_prog(-1, -1, -1);

        // Randomized programs against the timeline model.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) clear_chan();
            endpos = (n == 0) ? 16 : int'($urandom_range(0, 16));
            for (int i = 0; i < DEPTH; i++) begin
                if (i == endpos) prog[i] = '{OP_END, 8'h00, 0, 0};
                else prog[i] = '{2'($urandom_range(0, 2)), 8'($urandom),
                                 int'($urandom_range(0, 12)), int'($urandom_range(0, 6))};
            end
            load_prog();
            run_prog(-1, -1, -1);
        end

        // Mid-period reset restarts the CLOCK phase.
        for (int k = 0; k < 30 && (since % CLK_HALF) != 5; k++) @(negedge SIM_CLK);
        check("reached mid-period", 32'(since % CLK_HALF), 32'd5);
        SIM_RST = 1'b1;
        @(negedge SIM_CLK);
        check("mid reset {chan,busy,done,step_idx,CLOCK}",
              32'({chan, busy, done, step_idx, CLOCK}), 32'h0);
        SIM_RST = 1'b0;
        repeat (11) @(negedge SIM_CLK);
        check("CLOCK low 11 after reset", 32'(CLOCK), 32'h0);
        @(negedge SIM_CLK);
        check("CLOCK high 12 after reset", 32'(CLOCK), 32'h1);
        repeat (30) @(negedge SIM_CLK);

        clk_armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/agc_monitor_sequencer.md
Name: agc_monitor_sequencer

Overview:
- Synthesizable, table-driven stimulus sequencer for the AGC monitor and discrete inputs (MSTRT, MSTP, MNHRPT, etc.).
- Replaces fixed-delay initial-block stimulus, so the same start-up and stimulus sequences run in both simulation and FPGA builds.
- Holds a loadable step table and drives NCH output channels with set, clear and timed-pulse actions.
- Also generates the divided AGC CLOCK from SIM_CLK.

Parameters:
- NCH, 8, number of driven channels.
- DEPTH, 16, step-table entries (power of 2).
- TW, 24, delay-counter width in SIM_CLK cycles.
- PW, 16, pulse-length width.
- INIT_VAL, {NCH{1'b0}}, channel values after reset or abort.
- CLK_HALF, 12, SIM_CLK cycles per CLOCK half-period (must be ≥1).

Ports:
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  synchronous reset, active-high.
- wr_en  in  1  table write strobe.
- wr_addr  in  log2(DEPTH)  table write address.
- wr_op  in  2  op code: 0=SET, 1=CLR, 2=PULSE, 3=END.
- wr_mask  in  NCH  channel mask.
- wr_delay  in  TW  cycles to wait before the action.
- wr_plen  in  PW  pulse length.
- start  in  1  begin execution at entry 0.
- abort  in  1  stop execution and restore INIT_VAL.
- chan  out  NCH  driven channel levels.
- busy  out  1  high while running.
- done  out  1  one-cycle pulse at sequence end.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- step_idx  out  log2(DEPTH)  current entry.
- CLOCK  out  1  divided AGC clock.

Behaviour:
- Reset: chan=INIT_VAL, busy=0, done=0, wr_err=0, step_idx=0, CLOCK=0, state IDLE, divider count 0. Table contents are not reset; bench must load before start.
- Writes are accepted only in IDLE. A write while busy is discarded and wr_err pulses the next cycle.
- FSM states: IDLE, FETCH, WAIT, PULSE, DONE.
- IDLE: start → FETCH, busy=1 next cycle, step_idx=0.
- FETCH (1 cycle): latch the entry. op=END → DONE. Otherwise load the counter with delay → WAIT.
- WAIT:
  - Counter decrements each cycle; at 0 the action is applied (registered, visible next cycle).
  - SET: chan |= mask. CLR: chan &= ~mask. Then advance.
  - PULSE: chan |= mask, load plen (plen=0 treated as 1) → PULSE.
- PULSE: decrement the counter; at 0, chan &= ~mask, then advance.
- Advance: step_idx+1 → FETCH. If step_idx=DEPTH-1, go to DONE instead (no wrap).
- DONE (1 cycle): done=1, busy=0 → IDLE. chan holds its last value.
- Timing: for a step entering FETCH at cycle t, the SET/CLR/pulse-rise is visible at t+delay+2. A pulse stays high for exactly max(plen,1) cycles.
- Priority: SIM_RST > abort > start. abort in any non-IDLE state → IDLE, chan=INIT_VAL, busy=0, no done pulse. abort in IDLE also reloads INIT_VAL.
- start while busy is ignored. start in the same cycle as a DONE exit is ignored.
- Overlapping masks are allowed: a later SET/CLR overrides earlier levels per bit.
- CLOCK toggles every CLK_HALF SIM_CLK cycles, free-running and independent of the FSM. It is reset only by SIM_RST.

Decomposition:
- Package agc_seq_pkg: op-code localparams (OP_SET, OP_CLR, OP_PULSE, OP_END), state enum encoding, and the entry field widths/packing function.
- One sub-module, agc_clock_div: the parameterised CLK_HALF toggle divider.
- Step table is a flat register array inside the top; no RAM macro.

Test Plan:
1. Load {PULSE, mask=0x01, delay=2600, plen=250}, {END}; start at cycle 10 → chan[0] rises at cycle 2613, falls at 2863; done pulses once; busy low after.
2. Load {SET 0x05 d=0}, {CLR 0x04 d=3}, {END}; start → chan=0x05 two cycles after FETCH, then 0x01 five cycles later; step_idx reads 0,1,2.
3. Fill all 16 entries with SET, no END → done after entry 15; step_idx stays 15; no wrap to 0.
4. Start a PULSE with plen=100; assert abort at pulse cycle 40 → chan=INIT_VAL next cycle; busy=0; no done pulse; a subsequent start reruns from entry 0.
5. Write while busy → entry unchanged (verified on rerun); wr_err high exactly one cycle. start while busy → no restart.
6. CLK_HALF=12: after SIM_RST, CLOCK toggles every 12 cycles; assert SIM_RST mid-period → CLOCK=0 and phase restarts.
